// File: rtl/ifu_mem_responder.sv
// Instruction-fetch memory responder: word store with bench-side preload port,
// fixed-latency fully pipelined read path and a wrapping fetch counter.

// Simulation-only check that the fetch request is never unknown outside reset.
module ifu_mem_responder_chk (
  input logic clk,
  input logic reset,
  input logic ifu_rd_req
);

  a_req_known : assert property (@(posedge clk) disable iff (reset) !$isunknown(ifu_rd_req))
    else $error("ifu_rd_req is X/Z while not in reset");

endmodule

module ifu_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int READ_LAT   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_valid,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  fetch_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  generate
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
      $error("ifu_mem_responder: READ_LAT must be in 1..4");
    end
  endgenerate

  // Word store; deliberately left out of reset so preloaded images survive it.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Read pipeline: stage 0 captures the array word at the request edge.
  logic [READ_LAT-1:0]   vld_q;
  logic [READ_LAT-1:0]   vld_d;
  logic [DATA_WIDTH-1:0] dat_q [READ_LAT];
  logic [DATA_WIDTH-1:0] dat_d [READ_LAT];

  logic [CNT_WIDTH-1:0]  fetch_cnt_q;
  logic [CNT_WIDTH-1:0]  fetch_cnt_d;

  // Preload write; the pipeline reads mem_q before this edge updates it,
  // which gives read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset && ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  // Next-state for the shift pipeline and the fetch counter.
  always_comb begin
    vld_d = {READ_LAT{1'b0}};
    for (int i = 0; i < READ_LAT; i++) begin
      dat_d[i] = dat_q[i];
    end

    vld_d[0] = ifu_rd_req;
    dat_d[0] = mem_q[ifu_rd_addr];
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end

    // The last stage doubles as the data output register and holds when idle.
    if (vld_d[READ_LAT-1]) begin
      dat_d[READ_LAT-1] = dat_d[READ_LAT-1];
    end else begin
      dat_d[READ_LAT-1] = dat_q[READ_LAT-1];
    end

    if (ifu_rd_req) begin
      fetch_cnt_d = fetch_cnt_q + CNT_WIDTH'(1);
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
  end

  // State registers; reset drops every in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= {READ_LAT{1'b0}};
      fetch_cnt_q <= {CNT_WIDTH{1'b0}};
      for (int i = 0; i < READ_LAT; i++) begin
        dat_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      vld_q       <= vld_d;
      fetch_cnt_q <= fetch_cnt_d;
      for (int i = 0; i < READ_LAT; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign ifu_rd_valid = vld_q[READ_LAT-1];
  assign ifu_rd_data  = dat_q[READ_LAT-1];
  assign busy         = |vld_q;
  assign fetch_cnt    = fetch_cnt_q;

  ifu_mem_responder_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .ifu_rd_req (ifu_rd_req)
  );

endmodule

// File: tb/tb_ifu_mem_responder.sv
// Bench for ifu_mem_responder: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_ifu_mem_responder;

  localparam int AW    = 12;
  localparam int DW    = 12;
  localparam int LAT   = 2;
  localparam int CW    = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ifu_rd_req = 1'b0;
  logic [AW-1:0] ifu_rd_addr = '0;
  logic [DW-1:0] ifu_rd_data;
  logic          ifu_rd_valid;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          busy;
  logic [CW-1:0] fetch_cnt;

  int errors = 0;
  int checks = 0;

  ifu_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .READ_LAT   (LAT),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ifu_rd_req   (ifu_rd_req),
    .ifu_rd_addr  (ifu_rd_addr),
    .ifu_rd_data  (ifu_rd_data),
    .ifu_rd_valid (ifu_rd_valid),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .busy         (busy),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;   // edge after which the word is presented
    logic [DW-1:0] data;
  } pend_t;

  pend_t         pend[$];
  logic [DW-1:0] mem_m [DEPTH];
  int            edge_n = 0;
  bit            model_on = 1'b0;
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_busy = 1'b0;
  logic [CW-1:0] exp_cnt = '0;

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      pend.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_busy  = 1'b0;
      exp_cnt   = '0;
      model_on  = 1'b1;
    end else begin
      if (ifu_rd_req) begin
        pend.push_back('{due: edge_n + LAT - 1, data: mem_m[ifu_rd_addr]});
        exp_cnt = exp_cnt + 1'b1;
      end
      if (ld_en) mem_m[ld_addr] = ld_data;
      while (pend.size() > 0 && pend[0].due < edge_n) void'(pend.pop_front());
      exp_valid = (pend.size() > 0) && (pend[0].due == edge_n);
      if (exp_valid) exp_data = pend[0].data;
      exp_busy = (pend.size() > 0);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("m_valid", 32'(ifu_rd_valid), 32'(exp_valid));
      chk("m_data",  32'(ifu_rd_data),  32'(exp_data));
      chk("m_busy",  32'(busy),         32'(exp_busy));
      chk("m_cnt",   32'(fetch_cnt),    32'(exp_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rq, input logic [AW-1:0] ra,
                       input logic le, input logic [AW-1:0] la, input logic [DW-1:0] ldd);
    ifu_rd_req  = rq;
    ifu_rd_addr = ra;
    ld_en       = le;
    ld_addr     = la;
    ld_data     = ldd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    // 1: reset held 3 cycles then released idle
    reset = 1'b1;
    repeat (3) idle();
    reset = 1'b0;
    idle();
    chk("rst_valid", 32'(ifu_rd_valid), 32'd0);
    chk("rst_data",  32'(ifu_rd_data),  32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_cnt",   32'(fetch_cnt),    32'd0);

    // Fill the whole store so every address is known to the model.
    for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, 1'b1, AW'(a), DW'($urandom));

    // 2: single request, READ_LAT=2
    drive(1'b0, '0, 1'b1, 12'o0200, 12'o7300);
    drive(1'b1, 12'o0200, 1'b0, '0, '0);
    chk("t2_busy_n", 32'(busy),         32'd1);
    chk("t2_vld_n",  32'(ifu_rd_valid), 32'd0);
    idle();
    chk("t2_vld",    32'(ifu_rd_valid), 32'd1);
    chk("t2_data",   32'(ifu_rd_data),  32'o7300);
    chk("t2_cnt",    32'(fetch_cnt),    32'd1);
    idle();
    chk("t2_vld_off", 32'(ifu_rd_valid), 32'd0);
    chk("t2_hold",    32'(ifu_rd_data),  32'o7300);

    // 3: back-to-back requests
    for (int k = 0; k < 8; k++) drive(1'b0, '0, 1'b1, AW'(12'o0200 + k), DW'(k + 1));
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, AW'(12'o0200 + k - 1), 1'b0, '0, '0);
      chk("t3_busy", 32'(busy), 32'd1);
      if (k > 1) begin
        chk("t3_vld",  32'(ifu_rd_valid), 32'd1);
        chk("t3_data", 32'(ifu_rd_data),  32'(k - 1));
      end
    end
    idle();
    chk("t3_last_vld",  32'(ifu_rd_valid), 32'd1);
    chk("t3_last_data", 32'(ifu_rd_data),  32'd8);
    chk("t3_cnt",       32'(fetch_cnt),    32'd9);
    idle();
    chk("t3_busy_off", 32'(busy), 32'd0);

    // 4: read-before-write collision
    drive(1'b0, '0, 1'b1, 12'o0300, 12'o0005);
    drive(1'b1, 12'o0300, 1'b1, 12'o0300, 12'o1234);
    drive(1'b1, 12'o0300, 1'b0, '0, '0);
    chk("t4_old_vld",  32'(ifu_rd_valid), 32'd1);
    chk("t4_old_data", 32'(ifu_rd_data),  32'o0005);
    idle();
    chk("t4_new_vld",  32'(ifu_rd_valid), 32'd1);
    chk("t4_new_data", 32'(ifu_rd_data),  32'o1234);
    idle();

    // 5: reset with two requests in flight
    drive(1'b1, 12'o0201, 1'b0, '0, '0);
    drive(1'b1, 12'o0202, 1'b0, '0, '0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("t5_busy", 32'(busy),      32'd0);
    chk("t5_cnt",  32'(fetch_cnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("t5_no_vld", 32'(ifu_rd_valid), 32'd0);
      chk("t5_data",   32'(ifu_rd_data),  32'd0);
    end

    // 6: counter wrap and top address
    drive(1'b0, '0, 1'b1, 12'o7777, 12'o4321);
    for (int k = 0; k < 16; k++) drive(1'b1, AW'($urandom), 1'b0, '0, '0);
    drive(1'b1, 12'o7777, 1'b0, '0, '0);
    chk("t6_cnt_wrap", 32'(fetch_cnt), 32'd1);
    idle();
    chk("t6_top_vld",  32'(ifu_rd_valid), 32'd1);
    chk("t6_top_data", 32'(ifu_rd_data),  32'o4321);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(logic'($urandom_range(0, 3) != 0), AW'($urandom),
            logic'($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0) ? ifu_rd_addr : AW'($urandom),
            DW'($urandom));
    end
    reset = 1'b0;
    repeat (LAT + 2) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
